// File: rtl/ula_multiciclo.sv
// Sequential ALU with valid/ready handshakes, registered result and flags.
// Logic ops, add/sub, compares and shifts finish in one cycle; MUL/DIVU/REMU iterate WIDTH steps.
module ula_multiciclo #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             neg_flag
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_SLL  = 4'b1110;
    localparam logic [3:0] OP_SRL  = 4'b1111;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_neg;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_is_iter;

    logic [WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_iter_res;

    function automatic logic f_is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    // Single-cycle datapath evaluated straight from the operands being accepted
    always_comb begin
        w_sum   = {1'b0, in1} + {1'b0, in2};
        w_dif   = {1'b0, in1} - {1'b0, in2};
        w_shamt = in1[SHW-1:0];
        w_alu   = w_sum[WIDTH-1:0];
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (op)
            OP_AND:  w_alu = in1 & in2;
            OP_OR:   w_alu = in1 | in2;
            OP_ADD: begin
                w_alu   = w_sum[WIDTH-1:0];
                w_alu_c = w_sum[WIDTH];
                w_alu_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu   = w_dif[WIDTH-1:0];
                w_alu_c = w_dif[WIDTH];
                w_alu_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_dif[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_dif[WIDTH]};
            OP_NOR:  w_alu = ~(in1 | in2);
            OP_XOR:  w_alu = in1 ^ in2;
            OP_SLL:  w_alu = in2 << w_shamt;
            OP_SRL:  w_alu = in2 >> w_shamt;
            OP_SRA:  w_alu = $signed(in2) >>> w_shamt;
            // Reserved codes compute a sum but never raise carry/overflow
            default: w_alu = w_sum[WIDTH-1:0];
        endcase
    end

    // Operation class decode for the accept decision
    always_comb begin
        if ((op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU)) begin
            w_is_iter = 1'b1;
        end else begin
            w_is_iter = 1'b0;
        end
    end

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        w_mul_nxt = r_acc + (r_opb[0] ? r_opa : {WIDTH{1'b0}});
        w_rem_sh  = {r_acc, r_opa[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_opb};
        w_fit     = ~w_trial[WIDTH];
        w_rem_nxt = w_fit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quo_nxt = {r_opa[WIDTH-2:0], w_fit};
        case (r_op)
            OP_MUL:  w_iter_res = w_mul_nxt;
            OP_DIVU: w_iter_res = w_quo_nxt;
            default: w_iter_res = w_rem_nxt;
        endcase
    end

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 4'b0000;
            r_opa       <= {WIDTH{1'b0}};
            r_opb       <= {WIDTH{1'b0}};
            r_acc       <= {WIDTH{1'b0}};
            r_cnt       <= {SHW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_in_ready <= 1'b0;
                        if (w_is_iter) begin
                            r_opa   <= in1;
                            r_opb   <= in2;
                            r_acc   <= {WIDTH{1'b0}};
                            r_cnt   <= {SHW{1'b0}};
                            r_state <= S_BUSY;
                        end else begin
                            r_result    <= w_alu;
                            r_zero      <= f_is_zero(w_alu);
                            r_neg       <= w_alu[WIDTH-1];
                            r_carry     <= w_alu_c;
                            r_ovf       <= w_alu_v;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_nxt;
                        r_opa <= {r_opa[WIDTH-2:0], 1'b0};
                        r_opb <= {1'b0, r_opb[WIDTH-1:1]};
                    end else begin
                        r_acc <= w_rem_nxt;
                        r_opa <= w_quo_nxt;
                    end
                    r_cnt <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST_STEP) begin
                        r_result    <= w_iter_res;
                        r_zero      <= f_is_zero(w_iter_res);
                        r_neg       <= w_iter_res[WIDTH-1];
                        r_carry     <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
    assign ovf_flag   = r_ovf;
    assign neg_flag   = r_neg;

endmodule
